nibble_serial_adder: RTL and testbench

//  Multi-cycle WIDTH-bit adder that feeds the existing 4-bit adder (adder4) one

---
 rtl/nibble_serial_adder_pkg.sv | 25 ++
 rtl/nibble_serial_adder_adder4.sv | 22 ++
 rtl/nibble_serial_adder.sv | 139 +++++++++++++
 tb/tb_nibble_serial_adder.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/nibble_serial_adder_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : nibble_serial_adder_pkg
//  Purpose  : Shared types and helpers for the nibble-serial adder: the FSM
//             state encoding, the nibble width and the index-width helper.
//  Revision : 1.0 - initial release
// ============================================================================
package nibble_serial_adder_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of the nibble index counter; never narrower than one bit so that
  // a single-nibble configuration still has a legal counter.
  function automatic int idx_width(input int nibbles);
    return (nibbles <= 2) ? 1 : $clog2(nibbles);
  endfunction

endpackage
`default_nettype wire

// File: rtl/nibble_serial_adder_adder4.sv
`default_nettype none
// ============================================================================
//  Module   : adder4
//  Purpose  : Plain 4-bit ripple adder with carry in/out; the nibble datapath
//             driven by the nibble-serial sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
module adder4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in,
  output logic [3:0] sum,
  output logic       c_out
);

  // Single 5-bit addition gives both the nibble sum and the outgoing carry.
  always_comb begin
    {c_out, sum} = {1'b0, a} + {1'b0, b} + {4'b0000, c_in};
  end

endmodule
`default_nettype wire

// File: rtl/nibble_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module   : nibble_serial_adder
//  Purpose  : WIDTH-bit adder computed one nibble per clock through adder4,
//             LSB nibble first, with a registered carry between nibbles.
//             Valid/ready handshake on the operand and result sides.
//  Options  : define NIBBLE_SERIAL_ADDER_SUB_EN to add the 'sub' input, which
//             turns the operation into a - b - c_in.
//  Revision : 1.0 - initial release
// ============================================================================
module nibble_serial_adder #(
  parameter int WIDTH = 16   // must be a multiple of 4 and at least 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             busy
);
  import nibble_serial_adder_pkg::*;

  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int IDX_W   = idx_width(NIBBLES);
  localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(NIBBLES - 1);

  state_t               r_state;
  state_t               w_state_next;
  logic [WIDTH-1:0]     r_a;
  logic [WIDTH-1:0]     r_b;
  logic                 r_carry;
  logic [IDX_W-1:0]     r_idx;
  logic [WIDTH-1:0]     r_sum;
  logic                 r_c_out;
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
  logic                 r_sub;
`endif

  logic [NIBBLE_W-1:0]  w_a_nib;
  logic [NIBBLE_W-1:0]  w_b_nib;
  logic [NIBBLE_W-1:0]  w_nib_sum;
  logic                 w_nib_cout;
  logic                 w_last_nib;

  // Select the current operand nibbles; subtraction inverts B nibble-wise.
  always_comb begin
    w_a_nib    = r_a[r_idx*NIBBLE_W +: NIBBLE_W];
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    w_b_nib    = r_b[r_idx*NIBBLE_W +: NIBBLE_W] ^ {NIBBLE_W{r_sub}};
`else
    w_b_nib    = r_b[r_idx*NIBBLE_W +: NIBBLE_W];
`endif
    w_last_nib = (r_idx == c_last_idx);
  end

  adder4 u_adder4 (
    .a     (w_a_nib),
    .b     (w_b_nib),
    .c_in  (r_carry),
    .sum   (w_nib_sum),
    .c_out (w_nib_cout)
  );

  // State register; reset wins over any handshake in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state logic: accept in IDLE, one nibble per RUN cycle, hold in DONE.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (in_valid)   w_state_next = RUN;
      RUN:     if (w_last_nib) w_state_next = DONE;
      DONE:    if (out_ready)  w_state_next = IDLE;
      default:                 w_state_next = IDLE;
    endcase
  end

  // Operand capture on accept, then nibble-by-nibble sum and carry update.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_sum   <= '0;
      r_c_out <= 1'b0;
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
      r_sub   <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= b;
            r_idx   <= '0;
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
            r_sub   <= sub;
            r_carry <= c_in ^ sub;
`else
            r_carry <= c_in;
`endif
          end
        end
        RUN: begin
          r_sum[r_idx*NIBBLE_W +: NIBBLE_W] <= w_nib_sum;
          r_carry <= w_nib_cout;
          r_idx   <= r_idx + IDX_W'(1);
          if (w_last_nib) r_c_out <= w_nib_cout;
        end
        default: begin
        end
      endcase
    end
  end

  // Handshake and status outputs decode directly from the state register.
  always_comb begin
    in_ready  = (r_state == IDLE);
    out_valid = (r_state == DONE);
    busy      = (r_state != IDLE);
    sum       = r_sum;
    c_out     = r_c_out;
  end

endmodule
`default_nettype wire

// File: tb/tb_nibble_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_nibble_serial_adder
//  Purpose  : Directed self-checking bench for nibble_serial_adder (WIDTH=16).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_nibble_serial_adder;

  localparam int WIDTH = 16;
  localparam int LAT_LIMIT = 20;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
  logic             sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             busy;

  int errors = 0;
  int checks = 0;

  nibble_serial_adder #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_out     (c_out),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one operand set at a negedge and return just after the accept edge.
  task automatic issue(input logic [WIDTH-1:0] op_a, input logic [WIDTH-1:0] op_b,
                       input logic op_c);
    a        = op_a;
    b        = op_b;
    c_in     = op_c;
    in_valid = 1'b1;
    @(posedge clk);
  endtask

  // Count negedges from the accept until out_valid, bounded by LAT_LIMIT.
  task automatic wait_result(input logic keep_valid, output int lat);
    @(negedge clk);
    if (!keep_valid) in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < LAT_LIMIT) begin
      @(negedge clk);
      lat++;
    end
  endtask

  // Pulse out_ready for one cycle; ends at the negedge after return to IDLE.
  task automatic release_result();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (sum !== 16'h0000)   begin errors++; $display("FAIL reset_sum got=%h exp=0000", sum); end
    checks++; if (c_out !== 1'b0)     begin errors++; $display("FAIL reset_c_out got=%b exp=0", c_out); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    rst = 1'b0;
  endtask

  task automatic test_basic_add();
    int lat;
    issue(16'h1234, 16'h4321, 1'b0);
    wait_result(1'b0, lat);
    checks++; if (lat !== 4)        begin errors++; $display("FAIL add_latency got=%0d exp=4", lat); end
    checks++; if (sum !== 16'h5555) begin errors++; $display("FAIL add_sum got=%h exp=5555", sum); end
    checks++; if (c_out !== 1'b0)   begin errors++; $display("FAIL add_c_out got=%b exp=0", c_out); end
    checks++; if (busy !== 1'b1)    begin errors++; $display("FAIL add_busy_done got=%b exp=1", busy); end
    release_result();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL add_back_idle got=%b exp=1", in_ready); end
  endtask

  task automatic test_carry_ripple();
    int lat;
    issue(16'hFFFF, 16'h0001, 1'b0);
    wait_result(1'b0, lat);
    checks++; if (lat !== 4)        begin errors++; $display("FAIL ripple_latency got=%0d exp=4", lat); end
    checks++; if (sum !== 16'h0000) begin errors++; $display("FAIL ripple_sum got=%h exp=0000", sum); end
    checks++; if (c_out !== 1'b1)   begin errors++; $display("FAIL ripple_c_out got=%b exp=1", c_out); end
    release_result();
  endtask

  task automatic test_backpressure();
    int lat;
    issue(16'h8000, 16'h8000, 1'b1);
    wait_result(1'b0, lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL bp_latency got=%0d exp=4", lat); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid cyc=%0d got=%b exp=1", i, out_valid); end
      checks++; if (sum !== 16'h0001)   begin errors++; $display("FAIL bp_sum cyc=%0d got=%h exp=0001", i, sum); end
      checks++; if (c_out !== 1'b1)     begin errors++; $display("FAIL bp_c_out cyc=%0d got=%b exp=1", i, c_out); end
      checks++; if (in_ready !== 1'b0)  begin errors++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=0", i, in_ready); end
      @(negedge clk);
    end
    release_result();
    checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL bp_release_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_out_valid got=%b exp=0", out_valid); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL bp_release_busy got=%b exp=0", busy); end
    checks++; if (sum !== 16'h0001)   begin errors++; $display("FAIL bp_sum_held got=%h exp=0001", sum); end
  endtask

  task automatic test_abort();
    int lat;
    int seen;
    issue(16'h0F0F, 16'h0101, 1'b0);
    @(negedge clk);            // first RUN cycle
    in_valid = 1'b0;
    @(negedge clk);            // second RUN cycle
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL abort_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL abort_out_valid got=%b exp=0", out_valid); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL abort_busy got=%b exp=0", busy); end
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (out_valid) seen++;
      @(negedge clk);
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL abort_no_result got=%0d exp=0", seen); end
    issue(16'h0001, 16'h0001, 1'b0);
    wait_result(1'b0, lat);
    checks++; if (lat !== 4)        begin errors++; $display("FAIL abort_follow_latency got=%0d exp=4", lat); end
    checks++; if (sum !== 16'h0002) begin errors++; $display("FAIL abort_follow_sum got=%h exp=0002", sum); end
    checks++; if (c_out !== 1'b0)   begin errors++; $display("FAIL abort_follow_c_out got=%b exp=0", c_out); end
    release_result();
  endtask

  task automatic test_back_to_back();
    int lat;
    issue(16'h1111, 16'h2222, 1'b0);
    @(negedge clk);
    // Present the next operation immediately and hold it through RUN/DONE.
    a        = 16'hAAAA;
    b        = 16'h5555;
    c_in     = 1'b1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_in_ready_run got=%b exp=0", in_ready); end
    lat = 0;
    while (!out_valid && lat < LAT_LIMIT) begin
      @(negedge clk);
      lat++;
    end
    checks++; if (lat !== 4)        begin errors++; $display("FAIL b2b_first_latency got=%0d exp=4", lat); end
    checks++; if (sum !== 16'h3333) begin errors++; $display("FAIL b2b_first_sum got=%h exp=3333", sum); end
    checks++; if (c_out !== 1'b0)   begin errors++; $display("FAIL b2b_first_c_out got=%b exp=0", c_out); end
    release_result();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_idle_in_ready got=%b exp=1", in_ready); end
    @(posedge clk);            // second operation accepted here
    wait_result(1'b0, lat);
    checks++; if (lat !== 4)        begin errors++; $display("FAIL b2b_second_latency got=%0d exp=4", lat); end
    checks++; if (sum !== 16'h0000) begin errors++; $display("FAIL b2b_second_sum got=%h exp=0000", sum); end
    checks++; if (c_out !== 1'b1)   begin errors++; $display("FAIL b2b_second_c_out got=%b exp=1", c_out); end
    release_result();
  endtask

`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
  task automatic test_subtract();
    int lat;
    sub = 1'b1;
    issue(16'h0005, 16'h0007, 1'b0);
    wait_result(1'b0, lat);
    checks++; if (sum !== 16'hFFFE) begin errors++; $display("FAIL sub_neg_sum got=%h exp=fffe", sum); end
    checks++; if (c_out !== 1'b0)   begin errors++; $display("FAIL sub_neg_c_out got=%b exp=0", c_out); end
    release_result();
    issue(16'h0007, 16'h0005, 1'b0);
    wait_result(1'b0, lat);
    checks++; if (sum !== 16'h0002) begin errors++; $display("FAIL sub_pos_sum got=%h exp=0002", sum); end
    checks++; if (c_out !== 1'b1)   begin errors++; $display("FAIL sub_pos_c_out got=%b exp=1", c_out); end
    release_result();
    sub = 1'b0;
    issue(16'h0007, 16'h0005, 1'b0);
    wait_result(1'b0, lat);
    checks++; if (sum !== 16'h000C) begin errors++; $display("FAIL sub0_sum got=%h exp=000c", sum); end
    checks++; if (c_out !== 1'b0)   begin errors++; $display("FAIL sub0_c_out got=%b exp=0", c_out); end
    release_result();
  endtask
`endif

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    c_in      = 1'b0;
    out_ready = 1'b0;
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    sub       = 1'b0;
`endif
    test_reset();
    test_basic_add();
    test_carry_ripple();
    test_backpressure();
    test_abort();
    test_back_to_back();
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    test_subtract();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
